// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: controller states and the four
// SPI modes encoded as {CPOL,CPHA}.
package spi_pkg;

  typedef enum logic [1:0] {
    WAIT_CS_HIGH,
    IDLE,
    ACTIVE
  } spi_state_e;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_input_sync.sv
// Multi-stage synchroniser for one asynchronous SPI pin, with rise/fall
// detection against the previous synchronised value.
module spi_input_sync #(
  parameter int STAGES  = 2,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk) begin
    if (!reset) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign dout = chain[STAGES-1];
  assign rise = dout & ~prev;
  assign fall = ~dout & prev;

endmodule

// File: rtl/spi_slave_param.sv
// Oversampled SPI slave: synchronised pins, all four modes, MSB/LSB-first,
// multi-word bursts with a one-word transmit holding register.
module spi_slave_param
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  SCLK,
  input  logic                  CS,
  input  logic                  MOSI,
  output logic                  MISO,
  input  logic [DATA_WIDTH-1:0] txData,
  input  logic                  txValid,
  output logic                  txReady,
  output logic [DATA_WIDTH-1:0] rxData,
  output logic                  rxValid,
  output logic                  busy,
  output logic                  txUnderrun,
  output logic                  frameError
);

  localparam int         CW         = $clog2(DATA_WIDTH);
  localparam logic [1:0] MODE       = {CPOL, CPHA};
  localparam bit         IDLE_HIGH  = (MODE == MODE2) || (MODE == MODE3);
  localparam bit         SHIFT_LEAD = (MODE == MODE1) || (MODE == MODE3);

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s;
  logic [1:0] mosi_edges_unused;

  spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sclk (
    .clk(clk), .reset(reset), .din(SCLK),
    .dout(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  // CS resets low so a frame already in progress at reset is never joined.
  spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
    .clk(clk), .reset(reset), .din(CS),
    .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .din(MOSI),
    .dout(mosi_s), .rise(mosi_edges_unused[0]), .fall(mosi_edges_unused[1])
  );

  spi_state_e            state;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] rx_sr, tx_sr, hold_reg, next_word, rx_shifted;
  logic                  hold_full, miso_reg;
  logic                  lead_edge, trail_edge, sample_edge, shift_edge;
  logic                  wrap, word_start, accept;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
  endfunction

  assign lead_edge   = IDLE_HIGH ? sclk_fall : sclk_rise;
  assign trail_edge  = IDLE_HIGH ? sclk_rise : sclk_fall;
  assign sample_edge = SHIFT_LEAD ? trail_edge : lead_edge;
  assign shift_edge  = SHIFT_LEAD ? lead_edge : trail_edge;
  assign wrap        = (bit_cnt == CW'(DATA_WIDTH - 1));
  assign word_start  = ((state == IDLE) && cs_fall) ||
                       ((state == ACTIVE) && !cs_rise && sample_edge && wrap);
  assign accept      = txValid && !hold_full;
  assign next_word   = hold_full ? hold_reg : '0;
  assign rx_shifted  = MSB_FIRST ? {rx_sr[DATA_WIDTH-2:0], mosi_s}
                                 : {mosi_s, rx_sr[DATA_WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= WAIT_CS_HIGH;
      bit_cnt    <= '0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      hold_reg   <= '0;
      hold_full  <= 1'b0;
      miso_reg   <= 1'b0;
      rxData     <= '0;
      rxValid    <= 1'b0;
      txUnderrun <= 1'b0;
      frameError <= 1'b0;
    end else begin
      rxValid    <= 1'b0;
      txUnderrun <= 1'b0;
      frameError <= 1'b0;
      // A load and a write in the same cycle: load sees the old contents.
      hold_full  <= (hold_full && !word_start) || accept;
      if (accept) hold_reg <= txData;
      if (word_start) txUnderrun <= !hold_full;

      case (state)
        WAIT_CS_HIGH: if (cs_s) state <= IDLE;
        IDLE:         if (cs_fall) state <= ACTIVE;
        ACTIVE: begin
          if (cs_rise) begin
            state      <= IDLE;
            frameError <= (bit_cnt != '0);
            bit_cnt    <= '0;
            rx_sr      <= '0;
            miso_reg   <= 1'b0;
          end else begin
            if (sample_edge) begin
              rx_sr   <= rx_shifted;
              bit_cnt <= wrap ? '0 : bit_cnt + 1'b1;
              if (wrap) begin
                rxData  <= rx_shifted;
                rxValid <= 1'b1;
              end
            end
            // In CPHA=0 the trailing edge after a word's last sample must not
            // shift: the next word's first bit is already on MISO.
            if (shift_edge && (SHIFT_LEAD || bit_cnt != '0)) begin
              miso_reg <= first_bit(tx_sr);
              tx_sr    <= shift_out(tx_sr);
            end
          end
        end
        default: state <= WAIT_CS_HIGH;
      endcase

      if (word_start) begin
        if (SHIFT_LEAD) begin
          tx_sr <= next_word;
        end else begin
          miso_reg <= first_bit(next_word);
          tx_sr    <= shift_out(next_word);
        end
      end
    end
  end

  assign MISO    = miso_reg;
  assign txReady = !hold_full;
  assign busy    = (state == ACTIVE);

endmodule
